// File: rtl/ab_cond_pkg.sv
// Shared types and default parameters for the A/B input conditioner.
package ab_cond_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 4;

    // Per-channel debounce state. All four encodings are used, but the
    // FSM still recovers to ST_LO from anything unexpected.
    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_t;

endpackage

// File: rtl/ab_input_conditioner_debounce_ch.sv
// One conditioned channel: synchroniser chain, debounce FSM with a
// stability counter, and registered level / edge-pulse outputs.
//
// Counter meaning: while in a WAIT state, cnt_q holds how many further
// consecutive confirming cycles have been seen after the one that entered
// the WAIT state. A change is accepted on the edge where that count
// reaches DB_CYCLES-1, i.e. on the DB_CYCLES-th consecutive synchronised
// sample of the new level. With DB_CYCLES == 1 the first sample suffices
// and the FSM skips the WAIT state entirely.
module debounce_ch
    import ab_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;

    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          cnt_inc;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the raw input into the synchroniser; only the last stage is used.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Saturating increment: the counter never wraps past DB_CYCLES-1.
    assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);

    // Next-state, counter, level and pulse logic; defaults hold state and
    // clear the pulses so each pulse lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (sync) begin
                    cnt_d = '0;
                    if (DB_CYCLES == 1) begin
                        state_d = ST_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (!sync) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HI: begin
                if (!sync) begin
                    cnt_d = '0;
                    if (DB_CYCLES == 1) begin
                        state_d = ST_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LO;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (sync) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State registers; async reset clears everything and parks in ST_LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ab_input_conditioner.sv
// Conditions two independent bouncing inputs (a, b) for a downstream FSM.
// Pure structure: two identical channels sharing clock, reset and parameters.
module ab_input_conditioner
    import ab_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise,
    output logic a_fall,
    output logic b_fall
);

    debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_a),
        .level (a),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_b),
        .level (b),
        .rise  (b_rise),
        .fall  (b_fall)
    );

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Bench for ab_input_conditioner: a history-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ab_input_conditioner;
  import ab_cond_pkg::*;

  localparam int SS = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic a, b, a_rise, b_rise, a_fall, b_fall;

  int total = 0;
  int bad = 0;

  ab_input_conditioner #(.SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b),
    .a(a), .b(b), .a_rise(a_rise), .b_rise(b_rise),
    .a_fall(a_fall), .b_fall(b_fall)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endfunction

  function automatic void chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endfunction

  // Reference model: sync sample = raw from SS edges ago; the level flips
  // when the last DB sync samples all differ from the current level.
  logic [SS-1:0] raw_hist[2];
  logic [DB-1:0] sync_hist[2];
  logic          m_lvl[2];
  logic          m_rise[2];
  logic          m_fall[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        raw_hist[c]  <= '0;
        sync_hist[c] <= '0;
        m_lvl[c]     <= 1'b0;
        m_rise[c]    <= 1'b0;
        m_fall[c]    <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        logic          r;
        logic          s;
        logic [DB-1:0] sh;
        r  = (c == 0) ? raw_a : raw_b;
        s  = raw_hist[c][SS-1];
        sh = {sync_hist[c][DB-2:0], s};
        raw_hist[c]  <= {raw_hist[c][SS-2:0], r};
        sync_hist[c] <= sh;
        if (sh == {DB{~m_lvl[c]}}) begin
          m_lvl[c]  <= ~m_lvl[c];
          m_rise[c] <= ~m_lvl[c];
          m_fall[c] <= m_lvl[c];
        end else begin
          m_rise[c] <= 1'b0;
          m_fall[c] <= 1'b0;
        end
      end
    end
  end

  // scoreboard compare: every cycle, just after the active edge
  always @(posedge clk) begin
    #1;
    chk("sb_a", a, m_lvl[0]);
    chk("sb_a_rise", a_rise, m_rise[0]);
    chk("sb_a_fall", a_fall, m_fall[0]);
    chk("sb_b", b, m_lvl[1]);
    chk("sb_b_rise", b_rise, m_rise[1]);
    chk("sb_b_fall", b_fall, m_fall[1]);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all0(input string name);
    chk({name, "_a"}, a, 1'b0);
    chk({name, "_b"}, b, 1'b0);
    chk({name, "_ar"}, a_rise, 1'b0);
    chk({name, "_br"}, b_rise, 1'b0);
    chk({name, "_af"}, a_fall, 1'b0);
    chk({name, "_bf"}, b_fall, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [9:0] bounce_pat;

  initial begin
    // reset held with both raw inputs high
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all0("rst_hold");
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rel_a_low", a, 1'b0);
      chk("rel_b_low", b, 1'b0);
    end
    step();  // edge 6
    chk("rel_a_e6", a, 1'b1);
    chk("rel_ar_e6", a_rise, 1'b1);
    chk("rel_b_e6", b, 1'b1);
    chk("rel_br_e6", b_rise, 1'b1);
    step();  // edge 7
    chk("rel_a_e7", a, 1'b1);
    chk("rel_ar_e7", a_rise, 1'b0);
    idle(3);

    // clean fall then clean rise on a
    raw_a = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("fall_a_hold", a, 1'b1);
      chk("fall_af_hold", a_fall, 1'b0);
    end
    step();
    chk("fall_a_e6", a, 1'b0);
    chk("fall_af_e6", a_fall, 1'b1);
    step();
    chk("fall_af_e7", a_fall, 1'b0);
    idle(3);
    raw_a = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rise_a_hold", a, 1'b0);
    end
    step();
    chk("rise_a_e6", a, 1'b1);
    chk("rise_ar_e6", a_rise, 1'b1);
    step();
    chk("rise_ar_e7", a_rise, 1'b0);
    idle(3);

    // bring both low
    raw_a = 1'b0;
    raw_b = 1'b0;
    idle(8);
    chk_all0("settle1");

    // glitch: 3 cycles high on b
    raw_b = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) raw_b = 1'b0;
      step();
      chk("glitch_b", b, 1'b0);
      chk("glitch_br", b_rise, 1'b0);
      chk("glitch_bf", b_fall, 1'b0);
    end

    // bounce on a: 1,0,1,1,0,1,1,1,1,1 (first value on edge 1)
    bounce_pat = 10'b1111101101;
    for (int e = 1; e <= 10; e++) begin
      raw_a = bounce_pat[e-1];
      step();
      chk("bounce_a_low", a, 1'b0);
      chk("bounce_ar_low", a_rise, 1'b0);
    end
    raw_a = 1'b1;
    step();  // edge 11: fourth consecutive synchronised high
    chk("bounce_a_e11", a, 1'b1);
    chk("bounce_ar_e11", a_rise, 1'b1);
    step();
    chk("bounce_ar_e12", a_rise, 1'b0);
    raw_a = 1'b0;
    idle(8);
    chk_all0("settle2");

    // simultaneous rise on a and b
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("sim_a_low", a, 1'b0);
      chk("sim_b_low", b, 1'b0);
    end
    step();
    chk("sim_a_e6", a, 1'b1);
    chk("sim_b_e6", b, 1'b1);
    chk("sim_ar_e6", a_rise, 1'b1);
    chk("sim_br_e6", b_rise, 1'b1);
    raw_a = 1'b0;
    raw_b = 1'b0;
    idle(10);
    chk_all0("settle3");

    // reset asserted while a is waiting to go high
    raw_a = 1'b1;
    idle(4);
    chk2("mid_state_wait", dut.u_a.state_q, ST_WAIT_HI);
    #2;
    rst_n = 1'b0;
    raw_a = 1'b0;
    #1;
    chk_all0("mid_async");
    chk2("mid_state_lo", dut.u_a.state_q, ST_LO);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_a", a, 1'b0);
      chk("mid_ar", a_rise, 1'b0);
    end
    chk2("mid_state_end", dut.u_a.state_q, ST_LO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
